// File: rtl/register_file.sv
// 32 x 32-bit RV32 integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous active-low clear.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic                  RESET_N
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  // Only x1..x(NREGS-1) have storage; x0 is synthesised as a constant zero.
  logic [DATA_WIDTH-1:0] regs_q [1:NREGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NREGS-1];

  // RESET_N is qualified here so a floating (z) reset cannot corrupt state.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (WE3 && (RESET_N == 1'b1) && (A3 == ADDR_WIDTH'(i))) begin
        regs_d[i] = WD3;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (RESET_N == 1'b0) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes default to zero, which also covers address 0.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (A1 == ADDR_WIDTH'(i)) RD1 = regs_q[i];
      if (A2 == ADDR_WIDTH'(i)) RD2 = regs_q[i];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed corner cases followed by randomized traffic
// compared against an array-based model of the architectural registers.
module tb_register_file;

  logic        CLK;
  logic        WE3;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;
  logic        RESET_N;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .RD1(RD1), .RD2(RD2), .RESET_N(RESET_N)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Rising edge: architectural write rule, then settle.
  task automatic step();
    @(posedge CLK);
    if (RESET_N === 1'b1 && WE3 === 1'b1 && A3 != 5'd0) model[A3] = WD3;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd);
    @(negedge CLK);
    WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd1"}, RD1, exp_rd(A1));
    check({tag, "_rd2"}, RD2, exp_rd(A2));
  endtask

  initial begin
    RESET_N = 1'b0; WE3 = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'h0;
    clear_model();

    // Reset held for two cycles with a write attempt that must be ignored.
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'hDEADBEEF;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      A1 = 5'($urandom_range(1, 31)); A2 = 5'($urandom_range(1, 31)); #1;
      check("reset_rd1", RD1, 32'h0);
      check("reset_rd2", RD2, 32'h0);
    end
    A1 = 5'd7; #1;
    check("reset_write_ignored", RD1, 32'h0);
    @(negedge CLK);
    WE3 = 1'b0;
    RESET_N = 1'b1;

    // Write blocked when WE3 is low.
    drive(1'b0, 5'd1, 5'd0, 5'd1, 32'h0ABCDEF0);
    step();
    check("we_low_blocks", RD1, 32'h0);

    // Writes to x0 are discarded.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h0ABCDEF0);
    step();
    check("x0_rd1", RD1, 32'h0);
    check("x0_rd2", RD2, 32'h0);

    // Write x1, then read it in the same cycle as the address change.
    drive(1'b1, 5'd0, 5'd0, 5'd1, 32'h0ABCDEF0);
    step();
    drive(1'b0, 5'd1, 5'd0, 5'd0, 32'h0);
    check("x1_same_cycle", RD1, 32'h0ABCDEF0);

    // Read during write: old value before the edge, new value after.
    drive(1'b1, 5'd1, 5'd4, 5'd4, 32'hFFFFFFFF);
    check("rdw_before", RD2, 32'h0);
    step();
    check("rdw_after", RD2, 32'hFFFFFFFF);
    drive(1'b0, 5'd1, 5'd4, 5'd4, 32'h55555555);
    step();
    check("hold_x4", RD2, 32'hFFFFFFFF);
    check("hold_x1", RD1, 32'h0ABCDEF0);

    // Both ports on the same register.
    drive(1'b0, 5'd4, 5'd4, 5'd0, 32'h0);
    check("same_addr", RD1, RD2 === 32'hFFFFFFFF ? 32'hFFFFFFFF : 32'hFFFFFFFF);
    check("same_addr_rd2", RD2, 32'hFFFFFFFF);

    // Write x31, then assert reset mid-cycle without any clock edge.
    drive(1'b1, 5'd31, 5'd1, 5'd31, 32'h12345678);
    step();
    check("x31_written", RD1, 32'h12345678);
    WE3 = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    clear_model();
    check("async_reset_x31", RD1, 32'h0);
    check("async_reset_x1", RD2, 32'h0);
    #1;
    RESET_N = 1'b1;  // released mid-cycle; first write lands on the next edge
    drive(1'b1, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D);
    check("post_release_before", RD1, 32'h0);
    step();
    check("post_release_after", RD1, 32'hCAFEF00D);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1r, a2r, a3r;
      a1r = 5'($urandom_range(0, 31));
      a2r = ($urandom_range(0, 7) == 0) ? a1r : 5'($urandom_range(0, 31));
      a3r = ($urandom_range(0, 3) == 0) ? a2r : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), a1r, a2r, a3r, $urandom);
      check_reads("rand_pre");
      step();
      check_reads("rand_post");
      if ($urandom_range(0, 59) == 0) begin
        #2;
        RESET_N = 1'b0;
        #1;
        clear_model();
        check_reads("rand_reset");
        #1;
        RESET_N = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
